calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 35 +++
 rtl/calc_digit_accum.sv | 21 ++
 rtl/calc_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, ALU opcodes and FSM states.
package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'd16;
  localparam logic [4:0] KEY_SUB = 5'd17;
  localparam logic [4:0] KEY_MUL = 5'd18;
  localparam logic [4:0] KEY_DIV = 5'd19;
  localparam logic [4:0] KEY_EQ  = 5'd20;
  localparam logic [4:0] KEY_CLR = 5'd21;
  localparam logic [4:0] KEY_NEG = 5'd22;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ENTRY_A,
    OP_WAIT,
    ENTRY_B,
    ALU_REQ,
    ALU_WAIT,
    DISP_REQ,
    DISP_WAIT,
    ERROR
  } state_e;

  // Operator key codes 16..19 map directly onto opcodes through their low two bits.
  function automatic alu_op_e key_to_op(input logic [4:0] key);
    return alu_op_e'(key[1:0]);
  endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Operand entry arithmetic: decimal append, two's-complement negate and digit-limit detection.
module calc_digit_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIGITS = 5,
  parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [3:0]            digit_i,
  input  logic [CW-1:0]         count_i,
  output logic [DATA_WIDTH-1:0] append_o,
  output logic [DATA_WIDTH-1:0] negate_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o
);

  assign append_o = acc_i * DATA_WIDTH'(10) + DATA_WIDTH'(digit_i);
  assign negate_o = '0 - acc_i;
  assign count_o  = count_i + CW'(1);
  assign full_o   = (count_i >= CW'(MAX_DIGITS));

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: collects operands, drives the ALU and display handshakes.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            i_button_data,
  input  logic                  i_button_valid,
  output logic                  o_button_ready,
  input  logic                  i_2s_comp_mode,
  output logic [DATA_WIDTH-1:0] o_alu_input_a,
  output logic [DATA_WIDTH-1:0] o_alu_input_b,
  output logic [1:0]            o_alu_input_op,
  output logic                  o_alu_input_signed,
  output logic                  o_alu_input_valid,
  input  logic                  i_alu_input_ready,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_error,
  input  logic                  i_alu_result_valid,
  output logic                  o_alu_result_ready,
  output logic                  o_add_state_display,
  output logic                  o_sub_state_display,
  output logic                  o_mul_state_display,
  output logic                  o_div_state_display,
  output logic [DATA_WIDTH-1:0] o_display_data,
  output logic                  o_display_2s_comp,
  output logic                  o_display_valid,
  input  logic                  i_display_ready,
  input  logic                  i_display_done,
  output logic                  o_error
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e                state_q, state_d, ret_q, ret_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
  alu_op_e               op_q, op_d, pend_q, pend_d;
  logic                  op_vld_q, op_vld_d, chain_q, chain_d, fresh_q, fresh_d;
  logic                  alu_sgn_q, alu_sgn_d, disp_sgn_q, disp_sgn_d, armed_q;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  key_fire, is_digit, is_op, do_clear, in_b, replace;
  logic [DATA_WIDTH-1:0] acc_in, acc_append, acc_negate;
  logic [CW-1:0]         cnt_in, cnt_next;
  logic                  acc_full;

  assign is_digit = (i_button_data <= 5'd9);
  assign is_op    = (i_button_data >= KEY_ADD) && (i_button_data <= KEY_DIV);
  assign key_fire = i_button_valid && o_button_ready;
  assign do_clear = key_fire && (i_button_data == KEY_CLR);

  // A digit after an operator or after EQ starts a new operand from zero.
  assign in_b    = (state_q == ENTRY_B);
  assign replace = is_digit && ((state_q == OP_WAIT) || ((state_q == ENTRY_A) && fresh_q));
  assign acc_in  = replace ? '0 : (in_b ? b_q : a_q);
  assign cnt_in  = replace ? '0 : cnt_q;

  calc_digit_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_DIGITS(MAX_DIGITS),
    .CW        (CW)
  ) u_accum (
    .acc_i   (acc_in),
    .digit_i (i_button_data[3:0]),
    .count_i (cnt_in),
    .append_o(acc_append),
    .negate_o(acc_negate),
    .count_o (cnt_next),
    .full_o  (acc_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ENTRY_A;
      ret_q      <= ENTRY_A;
      a_q        <= '0;
      b_q        <= '0;
      disp_q     <= '0;
      op_q       <= ALU_ADD;
      pend_q     <= ALU_ADD;
      op_vld_q   <= 1'b0;
      chain_q    <= 1'b0;
      fresh_q    <= 1'b0;
      alu_sgn_q  <= 1'b0;
      disp_sgn_q <= 1'b0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      a_q        <= a_d;
      b_q        <= b_d;
      disp_q     <= disp_d;
      op_q       <= op_d;
      pend_q     <= pend_d;
      op_vld_q   <= op_vld_d;
      chain_q    <= chain_d;
      fresh_q    <= fresh_d;
      alu_sgn_q  <= alu_sgn_d;
      disp_sgn_q <= disp_sgn_d;
      cnt_q      <= cnt_d;
      armed_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    a_d        = a_q;
    b_d        = b_q;
    disp_d     = disp_q;
    op_d       = op_q;
    pend_d     = pend_q;
    op_vld_d   = op_vld_q;
    chain_d    = chain_q;
    fresh_d    = fresh_q;
    alu_sgn_d  = alu_sgn_q;
    disp_sgn_d = disp_sgn_q;
    cnt_d      = cnt_q;
    case (state_q)
      ENTRY_A, OP_WAIT, ENTRY_B: begin
        if (key_fire && is_digit && !acc_full) begin
          cnt_d      = cnt_next;
          disp_d     = acc_append;
          disp_sgn_d = i_2s_comp_mode;
          state_d    = DISP_REQ;
          if (state_q == ENTRY_A) begin
            a_d     = acc_append;
            fresh_d = 1'b0;
            ret_d   = ENTRY_A;
          end else begin
            b_d   = acc_append;
            ret_d = ENTRY_B;
          end
        end else if (key_fire && is_op) begin
          if (in_b) begin
            // Chained operator: finish the pending op first, latch this one with the result.
            pend_d    = key_to_op(i_button_data);
            chain_d   = 1'b1;
            alu_sgn_d = i_2s_comp_mode;
            state_d   = ALU_REQ;
          end else begin
            op_d     = key_to_op(i_button_data);
            op_vld_d = 1'b1;
            fresh_d  = 1'b0;
            state_d  = OP_WAIT;
          end
        end else if (key_fire && (i_button_data == KEY_EQ) && in_b) begin
          chain_d   = 1'b0;
          alu_sgn_d = i_2s_comp_mode;
          state_d   = ALU_REQ;
        end else if (key_fire && (i_button_data == KEY_NEG)) begin
          if (in_b) b_d = acc_negate;
          else      a_d = acc_negate;
          disp_d     = acc_negate;
          disp_sgn_d = i_2s_comp_mode;
          ret_d      = state_q;
          state_d    = DISP_REQ;
        end
      end
      ALU_REQ: if (i_alu_input_ready) state_d = ALU_WAIT;
      ALU_WAIT: begin
        if (i_alu_result_valid) begin
          if (i_alu_error) begin
            state_d = ERROR;
          end else begin
            a_d        = i_alu_result;
            disp_d     = i_alu_result;
            disp_sgn_d = i_2s_comp_mode;
            cnt_d      = '0;
            state_d    = DISP_REQ;
            if (chain_q) begin
              op_d     = pend_q;
              op_vld_d = 1'b1;
              ret_d    = OP_WAIT;
            end else begin
              op_vld_d = 1'b0;
              fresh_d  = 1'b1;
              ret_d    = ENTRY_A;
            end
          end
        end
      end
      DISP_REQ:  if (i_display_ready) state_d = DISP_WAIT;
      DISP_WAIT: if (i_display_done)  state_d = ret_q;
      ERROR: ;
      default:   state_d = ENTRY_A;
    endcase
    if (do_clear) begin
      a_d        = '0;
      b_d        = '0;
      op_vld_d   = 1'b0;
      op_d       = ALU_ADD;
      chain_d    = 1'b0;
      fresh_d    = 1'b0;
      cnt_d      = '0;
      disp_d     = '0;
      disp_sgn_d = i_2s_comp_mode;
      ret_d      = ENTRY_A;
      state_d    = DISP_REQ;
    end
  end

  assign o_button_ready      = armed_q && ((state_q == ENTRY_A) || (state_q == OP_WAIT) ||
                                           (state_q == ENTRY_B) || (state_q == ERROR));
  assign o_alu_input_a       = a_q;
  assign o_alu_input_b       = b_q;
  assign o_alu_input_op      = op_q;
  assign o_alu_input_signed  = alu_sgn_q;
  assign o_alu_input_valid   = (state_q == ALU_REQ);
  assign o_alu_result_ready  = (state_q == ALU_WAIT);
  assign o_add_state_display = op_vld_q && (op_q == ALU_ADD);
  assign o_sub_state_display = op_vld_q && (op_q == ALU_SUB);
  assign o_mul_state_display = op_vld_q && (op_q == ALU_MUL);
  assign o_div_state_display = op_vld_q && (op_q == ALU_DIV);
  assign o_display_data      = disp_q;
  assign o_display_2s_comp   = disp_sgn_q;
  assign o_display_valid     = (state_q == DISP_REQ);
  assign o_error             = (state_q == ERROR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed key sequences then random keys against a calculator model.
module tb_calc_sequencer;

  localparam int W   = 8;
  localparam int MD  = 3;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [4:0]   i_button_data = '0;
  logic         i_button_valid = 1'b0;
  logic         o_button_ready;
  logic         i_2s_comp_mode = 1'b0;
  logic [W-1:0] o_alu_input_a, o_alu_input_b;
  logic [1:0]   o_alu_input_op;
  logic         o_alu_input_signed, o_alu_input_valid;
  logic         i_alu_input_ready = 1'b0;
  logic [W-1:0] i_alu_result = '0;
  logic         i_alu_error = 1'b0, i_alu_result_valid = 1'b0;
  logic         o_alu_result_ready;
  logic         o_add_state_display, o_sub_state_display, o_mul_state_display, o_div_state_display;
  logic [W-1:0] o_display_data;
  logic         o_display_2s_comp, o_display_valid;
  logic         i_display_ready = 1'b0, i_display_done = 1'b0;
  logic         o_error;

  calc_sequencer #(.DATA_WIDTH(W), .MAX_DIGITS(MD)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_button_data(i_button_data), .i_button_valid(i_button_valid), .o_button_ready(o_button_ready),
    .i_2s_comp_mode(i_2s_comp_mode),
    .o_alu_input_a(o_alu_input_a), .o_alu_input_b(o_alu_input_b), .o_alu_input_op(o_alu_input_op),
    .o_alu_input_signed(o_alu_input_signed), .o_alu_input_valid(o_alu_input_valid),
    .i_alu_input_ready(i_alu_input_ready),
    .i_alu_result(i_alu_result), .i_alu_error(i_alu_error), .i_alu_result_valid(i_alu_result_valid),
    .o_alu_result_ready(o_alu_result_ready),
    .o_add_state_display(o_add_state_display), .o_sub_state_display(o_sub_state_display),
    .o_mul_state_display(o_mul_state_display), .o_div_state_display(o_div_state_display),
    .o_display_data(o_display_data), .o_display_2s_comp(o_display_2s_comp),
    .o_display_valid(o_display_valid), .i_display_ready(i_display_ready),
    .i_display_done(i_display_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int failures = 0;

  // Calculator model: phase 0 entering A, 1 operator latched, 2 entering B, 3 error.
  int mA, mB, mOp, mPhase, mDigits;
  bit mHasOp, mFresh;
  int dispQ[$];
  bit aluExp, aluSeen, expSgn, expErr;
  int expA, expB, expOp, expRes;
  int aluStall = 0;
  bit forceErr = 1'b0;
  bit resetInAluWait = 1'b0;
  int lastDisp = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    asserts++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int toSigned(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  task automatic modelReset();
    mA = 0; mB = 0; mOp = 0; mPhase = 0; mDigits = 0; mHasOp = 0; mFresh = 0;
    dispQ.delete();
  endtask

  task automatic modelClear();
    mA = 0; mB = 0; mHasOp = 0; mFresh = 0; mDigits = 0; mPhase = 0;
    dispQ.push_back(0);
  endtask

  task automatic modelOperate(input int nextOp, input bit chained);
    int a, b, r;
    bit err;
    aluExp = 1; expA = mA; expB = mB; expOp = mOp; expSgn = i_2s_comp_mode;
    a = expSgn ? toSigned(mA) : mA;
    b = expSgn ? toSigned(mB) : mB;
    err = forceErr;
    r = 0;
    case (mOp)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      default: if (b == 0) err = 1; else r = a / b;
    endcase
    r = ((r % MOD) + MOD) % MOD;
    expRes = r; expErr = err;
    if (err) mPhase = 3;
    else begin
      mA = r;
      dispQ.push_back(r);
      if (chained) begin mOp = nextOp; mHasOp = 1; mPhase = 1; end
      else begin mHasOp = 0; mFresh = 1; mPhase = 0; end
    end
  endtask

  task automatic modelKey(input int k);
    aluExp = 0; aluSeen = 0;
    if (mPhase == 3) begin
      if (k == 21) modelClear();
    end else if (k <= 9) begin
      if (mPhase == 1) begin mB = k; mDigits = 1; mPhase = 2; dispQ.push_back(mB); end
      else if (mPhase == 0 && mFresh) begin mA = k; mDigits = 1; mFresh = 0; dispQ.push_back(mA); end
      else if (mDigits < MD) begin
        mDigits++;
        if (mPhase == 0) begin mA = (mA * 10 + k) % MOD; dispQ.push_back(mA); end
        else begin mB = (mB * 10 + k) % MOD; dispQ.push_back(mB); end
      end
    end else if (k >= 16 && k <= 19) begin
      if (mPhase == 2) modelOperate(k - 16, 1);
      else begin mOp = k - 16; mHasOp = 1; mFresh = 0; mPhase = 1; end
    end else if (k == 20) begin
      if (mPhase == 2) modelOperate(0, 0);
    end else if (k == 21) begin
      modelClear();
    end else if (k == 22) begin
      if (mPhase == 2) begin mB = (MOD - mB) % MOD; dispQ.push_back(mB); end
      else begin mA = (MOD - mA) % MOD; dispQ.push_back(mA); end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_alu"}, {o_alu_input_a, o_alu_input_b, o_alu_input_op, o_alu_input_signed,
                               o_alu_input_valid, o_alu_result_ready}, 0);
    checkOutput({tag, "_ind"}, {o_add_state_display, o_sub_state_display, o_mul_state_display,
                               o_div_state_display}, 0);
    checkOutput({tag, "_disp"}, {o_display_data, o_display_2s_comp, o_display_valid, o_error}, 0);
    checkOutput({tag, "_ready"}, o_button_ready, 0);
  endtask

  task automatic pressKey(input int k);
    int w = 0;
    @(negedge clk);
    i_button_data = 5'(k);
    i_button_valid = 1'b1;
    while (!o_button_ready && w < 50) begin @(negedge clk); w++; end
    checkOutput("key_ready", o_button_ready, 1);
    @(negedge clk);
    i_button_valid = 1'b0;
  endtask

  // Plays ALU and display partner until the sequencer is back waiting for keys.
  task automatic serviceUntilIdle();
    int cyc = 0, doneDelay = 0, resDelay, e;
    bit waitDone = 0, finished = 0;
    resDelay = $urandom_range(0, 2);
    while (!finished) begin
      @(negedge clk);
      i_alu_input_ready = 0; i_alu_result_valid = 0; i_alu_error = 0;
      i_display_ready = 0; i_display_done = 0;
      cyc++;
      if (cyc > 300) begin
        checkOutput("service_timeout", 1, 0);
        finished = 1;
      end else if (o_alu_input_valid) begin
        checkOutput("alu_req_expected", aluExp && !aluSeen, 1);
        checkOutput("alu_a", o_alu_input_a, expA);
        checkOutput("alu_b", o_alu_input_b, expB);
        checkOutput("alu_op", o_alu_input_op, expOp);
        checkOutput("alu_signed", o_alu_input_signed, expSgn);
        if (aluStall > 0) aluStall--;
        else begin i_alu_input_ready = 1; aluSeen = 1; end
      end else if (o_alu_result_ready) begin
        if (resetInAluWait) begin
          #2 rst_n = 0;
          #1 checkAllZero("rst_alu_wait");
          @(negedge clk) rst_n = 1;
          modelReset();
          resetInAluWait = 0;
          finished = 1;
        end else if (resDelay > 0) resDelay--;
        else begin
          i_alu_result = W'(expRes); i_alu_error = expErr; i_alu_result_valid = 1;
        end
      end else if (o_display_valid) begin
        checkOutput("disp_expected", dispQ.size() > 0, 1);
        if (dispQ.size() > 0) begin
          e = dispQ.pop_front();
          checkOutput("disp_data", o_display_data, e);
        end
        checkOutput("disp_2s", o_display_2s_comp, i_2s_comp_mode);
        lastDisp = o_display_data;
        i_display_ready = 1;
        i_display_done = ($urandom_range(0, 2) == 0);
        waitDone = 1;
        doneDelay = $urandom_range(0, 3);
      end else if (waitDone) begin
        checkOutput("disp_wait_hold", o_button_ready, 0);
        if (doneDelay == 0) begin i_display_done = 1; waitDone = 0; end
        else doneDelay--;
      end else if (o_button_ready) begin
        finished = 1;
      end
    end
    checkOutput("disp_all_seen", dispQ.size(), 0);
    checkOutput("alu_seen", aluSeen, aluExp);
  endtask

  task automatic applyStimulus(input int k);
    modelKey(k);
    pressKey(k);
    serviceUntilIdle();
    checkOutput("indicators", {o_add_state_display, o_sub_state_display, o_mul_state_display,
                               o_div_state_display}, mHasOp ? (8 >> mOp) : 0);
    checkOutput("error_flag", o_error, mPhase == 3);
  endtask

  task automatic checkIdle(input string tag);
    repeat (4) begin
      @(negedge clk);
      checkOutput(tag, o_display_valid, 0);
    end
    checkOutput({tag, "_ready"}, o_button_ready, 1);
  endtask

  initial begin
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    checkAllZero("por");
    @(negedge clk) rst_n = 1;
    modelReset();
    checkIdle("idle_after_por");

    // 12 + 3 = 15
    applyStimulus(1); applyStimulus(2); applyStimulus(16); applyStimulus(3); applyStimulus(20);
    checkOutput("add_result", lastDisp, 15);
    applyStimulus(21);

    // 5 * 4 chained into - 2
    applyStimulus(5); applyStimulus(18);
    checkOutput("mul_indicator", {o_add_state_display, o_sub_state_display, o_mul_state_display,
                                  o_div_state_display}, 4'b0010);
    applyStimulus(4); applyStimulus(17);
    checkOutput("chain_result", lastDisp, 20);
    checkOutput("sub_indicator", {o_add_state_display, o_sub_state_display, o_mul_state_display,
                                  o_div_state_display}, 4'b0100);
    applyStimulus(2); applyStimulus(20);
    checkOutput("sub_result", lastDisp, 18);

    // Divide by zero reports an error; only CLR recovers
    applyStimulus(7); applyStimulus(19); applyStimulus(0); applyStimulus(20);
    checkOutput("div0_error", o_error, 1);
    applyStimulus(3);
    checkOutput("error_holds", o_error, 1);
    applyStimulus(21);
    checkOutput("clr_error", o_error, 0);
    checkOutput("clr_display", lastDisp, 0);

    // 256 wraps to 0 at 8 bits, fourth digit ignored
    applyStimulus(2); applyStimulus(5); applyStimulus(6);
    checkOutput("wrap_256", lastDisp, 0);
    applyStimulus(9);
    applyStimulus(21);

    // ALU stalls for 10 cycles, then a reset lands while the result is awaited
    applyStimulus(4); applyStimulus(16); applyStimulus(3);
    aluStall = 10;
    applyStimulus(20);
    checkOutput("stall_result", lastDisp, 7);
    applyStimulus(6); applyStimulus(17); applyStimulus(2);
    resetInAluWait = 1;
    applyStimulus(20);
    checkIdle("idle_after_reset");

    for (int n = 0; n < 250; n++) begin
      int r, k;
      r = $urandom_range(0, 99);
      if (r < 45)      k = $urandom_range(0, 9);
      else if (r < 75) k = $urandom_range(16, 19);
      else if (r < 85) k = 20;
      else if (r < 91) k = 22;
      else if (r < 95) k = 21;
      else             k = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 15) : $urandom_range(23, 31);
      if ($urandom_range(0, 9) == 0) i_2s_comp_mode = ~i_2s_comp_mode;
      aluStall = $urandom_range(0, 3);
      forceErr = ($urandom_range(0, 19) == 0);
      applyStimulus(k);
      forceErr = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
